mw_pipe_reg: RTL and testbench

- M→W pipeline register of the P6 five-stage MIPS core. Sits directly downstream of the M-stage destination select and consumes its resolved `M_TrueA3`.
- Captures the M-stage payload each cycle, ages the hazard `Tnew` field, and supports stall-hold and bubble-flush.
- Produces the W-stage GRF write port (`W_A3`, `W_WD`, `W_WE`) plus the `W_PC` and `W_Instr` values used by the test harness.

---
 rtl/mw_pipe_reg.sv | 136 +++++++++++++
 tb/tb_mw_pipe_reg.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mw_pipe_reg.sv
// mw_pipe_reg: M->W pipeline register of the P6 five-stage MIPS core.
// Captures the M-stage payload, ages the hazard Tnew field, and supports
// stall-hold and bubble-flush. It drives the W-stage GRF write port and
// exposes W_PC/W_Instr to the test harness.
// Optional feature: define MW_RETIRE_CNT_EN to add the W_RetireCnt output,
// a free-running count of retired (valid, loaded) instructions.
module mw_pipe_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        M_Stall,
    input  logic        M_Flush,
    input  logic        M_Valid,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_Instr,
    input  logic [4:0]  M_TrueA3,
    input  logic        M_RegWrite,
    input  logic [31:0] M_ALUOut,
    input  logic [31:0] M_DMRD,
    input  logic [31:0] M_HILO,
    input  logic [1:0]  M_WDSel,
    input  logic [1:0]  M_Tnew,
    output logic        W_Valid,
    output logic [31:0] W_PC,
    output logic [31:0] W_Instr,
    output logic [4:0]  W_A3,
    output logic [31:0] W_WD,
    output logic        W_WE,
    output logic [1:0]  W_Tnew
`ifdef MW_RETIRE_CNT_EN
    ,
    output logic [31:0] W_RetireCnt
`endif
);

    // Write-data source codes carried in M_WDSel.
    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_DM   = 2'd1;
    localparam logic [1:0] WD_PC8  = 2'd2;
    localparam logic [1:0] WD_HILO = 2'd3;

    // Everything the W stage needs, held as one record so flush/stall/load
    // act on all fields together.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  a3;
        logic        regwrite;
        logic [31:0] aluout;
        logic [31:0] dmrd;
        logic [31:0] hilo;
        logic [1:0]  wdsel;
        logic [1:0]  tnew;
    } mw_payload_t;

    mw_payload_t payload_q, payload_d;
    logic        load_en;

    // A real load happens only when neither flush nor stall is asserted.
    assign load_en = !M_Flush && !M_Stall;

    // Next-state select with priority flush > stall > load.
    always_comb begin
        // NOTE: default every always_comb output first so no path can infer a latch.
        payload_d = payload_q;
        if (M_Flush) begin
            payload_d = '0;
        end else if (!M_Stall) begin
            payload_d.valid    = M_Valid;
            payload_d.pc       = M_PC;
            payload_d.instr    = M_Instr;
            payload_d.a3       = M_TrueA3;
            payload_d.regwrite = M_RegWrite;
            payload_d.aluout   = M_ALUOut;
            payload_d.dmrd     = M_DMRD;
            payload_d.hilo     = M_HILO;
            payload_d.wdsel    = M_WDSel;
            // Tnew ages by one stage and saturates at zero instead of wrapping.
            payload_d.tnew     = (M_Tnew == 2'd0) ? 2'd0 : M_Tnew - 2'd1;
        end
    end

    // Pipeline register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            payload_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            payload_q <= payload_d;
        end
    end

    // GRF write-data mux driven purely from the stored fields; PC+8 wraps mod 2^32.
    always_comb begin
        W_WD = payload_q.aluout;
        case (payload_q.wdsel)
            WD_ALU:  W_WD = payload_q.aluout;
            WD_DM:   W_WD = payload_q.dmrd;
            WD_PC8:  W_WD = payload_q.pc + 32'd8;
            WD_HILO: W_WD = payload_q.hilo;
            default: W_WD = payload_q.aluout;
        endcase
    end

    assign W_Valid = payload_q.valid;
    assign W_PC    = payload_q.pc;
    assign W_Instr = payload_q.instr;
    assign W_A3    = payload_q.a3;
    assign W_Tnew  = payload_q.tnew;
    // Writes to $0 are never enabled; the address itself is still shown.
    assign W_WE    = payload_q.valid & payload_q.regwrite & (payload_q.a3 != 5'd0);

`ifdef MW_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q, retire_cnt_d;

    // Count only edges that actually load a valid instruction; wraps naturally.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (load_en && M_Valid) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retire counter register, cleared with the pipeline fields.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign W_RetireCnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mw_pipe_reg.sv
// tb_mw_pipe_reg: directed, table-driven bench for mw_pipe_reg, plus
// hand-written sequences for reset and the optional retire counter.
module tb_mw_pipe_reg;

    logic        clk;
    logic        reset;
    logic        M_Stall, M_Flush, M_Valid, M_RegWrite;
    logic [31:0] M_PC, M_Instr, M_ALUOut, M_DMRD, M_HILO;
    logic [4:0]  M_TrueA3;
    logic [1:0]  M_WDSel, M_Tnew;
    logic        W_Valid, W_WE;
    logic [31:0] W_PC, W_Instr, W_WD;
    logic [4:0]  W_A3;
    logic [1:0]  W_Tnew;
`ifdef MW_RETIRE_CNT_EN
    logic [31:0] W_RetireCnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    mw_pipe_reg dut (
        .clk        (clk),
        .reset      (reset),
        .M_Stall    (M_Stall),
        .M_Flush    (M_Flush),
        .M_Valid    (M_Valid),
        .M_PC       (M_PC),
        .M_Instr    (M_Instr),
        .M_TrueA3   (M_TrueA3),
        .M_RegWrite (M_RegWrite),
        .M_ALUOut   (M_ALUOut),
        .M_DMRD     (M_DMRD),
        .M_HILO     (M_HILO),
        .M_WDSel    (M_WDSel),
        .M_Tnew     (M_Tnew),
        .W_Valid    (W_Valid),
        .W_PC       (W_PC),
        .W_Instr    (W_Instr),
        .W_A3       (W_A3),
        .W_WD       (W_WD),
        .W_WE       (W_WE),
        .W_Tnew     (W_Tnew)
`ifdef MW_RETIRE_CNT_EN
        ,
        .W_RetireCnt(W_RetireCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        // inputs
        logic        stall, flush, valid, rw;
        logic [31:0] pc, instr, alu, dmrd, hilo;
        logic [4:0]  a3;
        logic [1:0]  wdsel, tnew;
        // expected outputs after the edge
        logic        e_valid, e_we;
        logic [31:0] e_pc, e_instr, e_wd;
        logic [4:0]  e_a3;
        logic [1:0]  e_tnew;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic vec_t mk(input logic stall, input logic flush, input logic valid,
                                input logic [31:0] pc, input logic [31:0] instr,
                                input logic [4:0] a3, input logic rw, input logic [31:0] alu,
                                input logic [31:0] dmrd, input logic [31:0] hilo,
                                input logic [1:0] wdsel, input logic [1:0] tnew,
                                input logic e_valid, input logic [31:0] e_pc,
                                input logic [31:0] e_instr, input logic [4:0] e_a3,
                                input logic [31:0] e_wd, input logic e_we,
                                input logic [1:0] e_tnew);
        vec_t v;
        v.stall = stall; v.flush = flush; v.valid = valid; v.pc = pc; v.instr = instr;
        v.a3 = a3; v.rw = rw; v.alu = alu; v.dmrd = dmrd; v.hilo = hilo;
        v.wdsel = wdsel; v.tnew = tnew;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr; v.e_a3 = e_a3;
        v.e_wd = e_wd; v.e_we = e_we; v.e_tnew = e_tnew;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        M_Stall = v.stall; M_Flush = v.flush; M_Valid = v.valid;
        M_PC = v.pc; M_Instr = v.instr; M_TrueA3 = v.a3; M_RegWrite = v.rw;
        M_ALUOut = v.alu; M_DMRD = v.dmrd; M_HILO = v.hilo;
        M_WDSel = v.wdsel; M_Tnew = v.tnew;
    endtask

    task automatic check_outputs(input string tag, input logic valid, input logic [31:0] pc,
                                 input logic [31:0] instr, input logic [4:0] a3,
                                 input logic [31:0] wd, input logic we, input logic [1:0] tnew);
        check({tag, ".W_Valid"}, {31'd0, W_Valid}, {31'd0, valid});
        check({tag, ".W_PC"},    W_PC, pc);
        check({tag, ".W_Instr"}, W_Instr, instr);
        check({tag, ".W_A3"},    {27'd0, W_A3}, {27'd0, a3});
        check({tag, ".W_WD"},    W_WD, wd);
        check({tag, ".W_WE"},    {31'd0, W_WE}, {31'd0, we});
        check({tag, ".W_Tnew"},  {30'd0, W_Tnew}, {30'd0, tnew});
    endtask

    task automatic clear_inputs();
        M_Stall = 0; M_Flush = 0; M_Valid = 0; M_RegWrite = 0;
        M_PC = 0; M_Instr = 0; M_ALUOut = 0; M_DMRD = 0; M_HILO = 0;
        M_TrueA3 = 0; M_WDSel = 0; M_Tnew = 0;
    endtask

    initial begin
        //            stl flu val pc            instr         a3  rw alu           dmrd          hilo          sel  tn    eV ePC           eInstr        eA3 eWD           eWE eTn
        vecs[0]  = mk(0, 0, 1, 32'h0000_3000, 32'h1111_1111, 5,  1, 32'h0000_1234, 32'h0,        32'h0,        2'd0, 2'd2, 1, 32'h0000_3000, 32'h1111_1111, 5,  32'h0000_1234, 1, 2'd1);
        vecs[1]  = mk(0, 0, 1, 32'h0000_3010, 32'h2222_2222, 31, 1, 32'h0000_AAAA, 32'h0,        32'h0,        2'd2, 2'd3, 1, 32'h0000_3010, 32'h2222_2222, 31, 32'h0000_3018, 1, 2'd2);
        vecs[2]  = mk(0, 0, 1, 32'h0000_3014, 32'h3333_3333, 8,  1, 32'h0000_0001, 32'hFFFF_8000, 32'h0,        2'd1, 2'd1, 1, 32'h0000_3014, 32'h3333_3333, 8,  32'hFFFF_8000, 1, 2'd0);
        vecs[3]  = mk(0, 0, 1, 32'h0000_3018, 32'h4444_4444, 9,  1, 32'h0000_0002, 32'h0,        32'hCAFE_BABE, 2'd3, 2'd0, 1, 32'h0000_3018, 32'h4444_4444, 9,  32'hCAFE_BABE, 1, 2'd0);
        vecs[4]  = mk(0, 0, 1, 32'h0000_301C, 32'h5555_5555, 0,  1, 32'h0000_DEAD, 32'h0,        32'h0,        2'd0, 2'd1, 1, 32'h0000_301C, 32'h5555_5555, 0,  32'h0000_DEAD, 0, 2'd0);
        vecs[5]  = mk(0, 0, 1, 32'h0000_3020, 32'h6666_6666, 4,  0, 32'h0000_0055, 32'h0,        32'h0,        2'd0, 2'd0, 1, 32'h0000_3020, 32'h6666_6666, 4,  32'h0000_0055, 0, 2'd0);
        vecs[6]  = mk(0, 0, 0, 32'h0000_3024, 32'h7777_7777, 4,  1, 32'h0000_0077, 32'h0,        32'h0,        2'd0, 2'd0, 0, 32'h0000_3024, 32'h7777_7777, 4,  32'h0000_0077, 0, 2'd0);
        vecs[7]  = mk(0, 0, 1, 32'hFFFF_FFFC, 32'h8888_8888, 31, 1, 32'h0000_0011, 32'h0,        32'h0,        2'd2, 2'd2, 1, 32'hFFFF_FFFC, 32'h8888_8888, 31, 32'h0000_0004, 1, 2'd1);
        vecs[8]  = mk(0, 0, 1, 32'h0000_3020, 32'h9999_9999, 6,  1, 32'h0000_0099, 32'h0,        32'h0,        2'd0, 2'd2, 1, 32'h0000_3020, 32'h9999_9999, 6,  32'h0000_0099, 1, 2'd1);
        // Stalls with changing inputs: W must hold vecs[8] contents, Tnew not aged.
        vecs[9]  = mk(1, 0, 1, 32'h0000_4000, 32'hAAAA_AAAA, 7,  1, 32'h0000_0100, 32'h0,        32'h0,        2'd1, 2'd3, 1, 32'h0000_3020, 32'h9999_9999, 6,  32'h0000_0099, 1, 2'd1);
        vecs[10] = mk(1, 0, 0, 32'h0000_4004, 32'hBBBB_BBBB, 0,  0, 32'h0000_0200, 32'h1,        32'h2,        2'd2, 2'd0, 1, 32'h0000_3020, 32'h9999_9999, 6,  32'h0000_0099, 1, 2'd1);
        vecs[11] = mk(1, 0, 1, 32'h0000_4008, 32'hCCCC_CCCC, 3,  1, 32'h0000_0300, 32'h3,        32'h4,        2'd3, 2'd2, 1, 32'h0000_3020, 32'h9999_9999, 6,  32'h0000_0099, 1, 2'd1);
        // Flush wins over stall, then flush alone: both give a bubble.
        vecs[12] = mk(1, 1, 1, 32'h0000_400C, 32'hDDDD_DDDD, 3,  1, 32'h0000_0400, 32'h0,        32'h0,        2'd0, 2'd2, 0, 32'h0,         32'h0,         0,  32'h0,         0, 2'd0);
        vecs[13] = mk(0, 1, 1, 32'h0000_4010, 32'hEEEE_EEEE, 2,  1, 32'h0000_0500, 32'h0,        32'h0,        2'd2, 2'd3, 0, 32'h0,         32'h0,         0,  32'h0,         0, 2'd0);

        // Reset held for two cycles.
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 2'd0);
`ifdef MW_RETIRE_CNT_EN
        check("reset.W_RetireCnt", W_RetireCnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors, one edge each.
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_pc, vecs[i].e_instr,
                          vecs[i].e_a3, vecs[i].e_wd, vecs[i].e_we, vecs[i].e_tnew);
        end
`ifdef MW_RETIRE_CNT_EN
        // Valid loads in the table: vecs 0-5, 7, 8.
        check("table.W_RetireCnt", W_RetireCnt, 32'd8);
`endif

        // Async reset between edges after a valid load.
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check("preload.W_Valid", {31'd0, W_Valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_outputs("async_rst", 0, 32'h0, 32'h0, 5'd0, 32'h0, 0, 2'd0);
`ifdef MW_RETIRE_CNT_EN
        check("async_rst.W_RetireCnt", W_RetireCnt, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;

`ifdef MW_RETIRE_CNT_EN
        // 4 valid loads, 1 stall, 1 flush, 1 invalid load -> 4.
        for (int i = 0; i < 4; i++) begin
            drive(vecs[i]);
            @(posedge clk);
            #1;
        end
        M_Stall = 1; M_Valid = 1;
        @(posedge clk);
        #1;
        M_Stall = 0; M_Flush = 1;
        @(posedge clk);
        #1;
        M_Flush = 0; M_Valid = 0;
        @(posedge clk);
        #1;
        check("retire.W_RetireCnt", W_RetireCnt, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
